vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Free-running raster scan generator that drives the pixel-position side of the display path. It produces x/y/candraw for the renderer, which turns them into colour, memory address and blank. It also produces the hsync/vsync pulses for the VGA DAC, delayed to line up with the renderer's registered colour output, plus frame/line strobes for the game-of-life update logic. One pixel per clk; all outputs are registered.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
SYNC_DELAY, 1, clk cycles of delay on hsync/vsync relative to x/y (0..4)

Ports:
clk  input  1  pixel clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
x  output  11  current horizontal position, 0..H_TOTAL-1
y  output  11  current line, 0..V_TOTAL-1
candraw  output  1  high when (x,y) is in the visible area
hsync  output  1  horizontal sync, level SYNC_POL when asserted
vsync  output  1  vertical sync, level SYNC_POL when asserted
line_start  output  1  one-cycle strobe, high when x==0
frame_start  output  1  one-cycle strobe, high when x==0 && y==0

Behaviour:
- Derived values:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
  - Both totals must be ≤ 2047; checked at elaboration.
- Reset, any edge with rst=1, regardless of current state:
  - x=H_TOTAL-1, y=V_TOTAL-1.
  - candraw=0, line_start=0, frame_start=0.
  - hsync=vsync=!SYNC_POL.
  - Entire sync delay pipeline filled with !SYNC_POL.
  - These values match the last position of a frame, so no glitch occurs on release.
- Counting, each edge with rst=0:
  - If x==H_TOTAL-1, then x←0. Also, if y==V_TOTAL-1 then y←0, else y←y+1.
  - Otherwise x←x+1, y unchanged.
  - The first edge after reset release always gives x=0, y=0.
- Flags, registered and aligned with the x/y they describe (zero latency relative to x/y):
  - candraw = (x<H_VISIBLE) && (y<V_VISIBLE).
  - line_start = (x==0).
  - frame_start = (x==0 && y==0).
  - Flags are computed from the next counter values, so they never lag x/y.
- Sync window, undelayed:
  - hs_raw asserted iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vs_raw asserted iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for whole lines including their blanking pixels.
- Sync delay:
  - hsync/vsync equal hs_raw/vs_raw delayed by SYNC_DELAY cycles through a shift register. SYNC_DELAY=0 gives direct output.
  - The default of 1 matches the renderer's single registered stage.
- Frame period is exactly H_TOTAL*V_TOTAL cycles; candraw is high for exactly H_VISIBLE*V_VISIBLE of them.
- Boundaries:
  - Line wrap and frame wrap happen on the same edge when x==H_TOTAL-1 and y==V_TOTAL-1.
  - Reset mid-frame, including inside a sync pulse, deasserts syncs on the next edge.
  - No input other than rst affects timing.

Test Plan:
- Reset values: hold rst=1 for 3 cycles -> x=799, y=524, candraw=0, hsync=vsync=1, strobes 0. Release -> next cycle x=0, y=0, candraw=1, line_start=1, frame_start=1.
- Line wrap: run to x=799, y=0 -> next cycle x=0, y=1, line_start=1, frame_start=0. Check candraw=0 for x=640..799 and 1 for x=0..639 on y=0.
- hsync timing (defaults, SYNC_DELAY=1) -> hsync low exactly in the cycles where x=657..752 (96 cycles), high elsewhere; repeats every 800 cycles.
- Frame wrap and vsync -> vsync low for exactly 1600 consecutive cycles, starting one cycle after x=0,y=490. At x=799, y=524 -> next x=0, y=0, frame_start=1. Frame period is 420000 cycles and candraw count per frame is 307200.
- Reset mid-sync: assert rst while x=700, y=491 -> next edge: syncs inactive, x=799, y=524. After release, a full clean frame starts from x=0, y=0.
- Reduced parameters (H 8/2/2/2, V 4/1/1/1, SYNC_DELAY=0) -> period 14×7=98 cycles; hsync asserted at x=10..11 with no delay; vsync asserted on y=5.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running raster scan generator, one pixel per clk. All outputs are registered.
//
// Ports:
//   clk          pixel clock; all logic is on the rising edge
//   rst          synchronous, active-high reset
//   x, y         current pixel position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   candraw      high while (x,y) lies in the visible area
//   hsync/vsync  sync pulses at level SYNC_POL when asserted. They are delayed by
//                SYNC_DELAY clocks so that they line up with the renderer's
//                registered colour output.
//   line_start   one-cycle strobe while x==0
//   frame_start  one-cycle strobe while x==0 && y==0
//
// Reset parks the counters at the final position of a frame, with every sync
// stage inactive. The first edge after release therefore lands cleanly on (0,0).
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_POL   = 0,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        candraw,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] Y_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = (SYNC_POL == 0);

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end

    logic [10:0] x_nxt;
    logic [10:0] y_nxt;
    logic        hs_on;
    logic        vs_on;
    logic        hs_p0;
    logic        vs_p0;

    // Next position. All flags are derived from it, so they stay aligned with x/y.
    always_comb begin
        x_nxt = x + 11'd1;
        y_nxt = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? 11'd0 : y + 11'd1;
        end
        hs_on = (x_nxt >= HS_START) && (x_nxt < HS_END);
        vs_on = (y_nxt >= VS_START) && (y_nxt < VS_END);
    end

    // Stage p0: counters, flags and the undelayed sync levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            candraw     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_p0       <= SYNC_OFF;
            vs_p0       <= SYNC_OFF;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            candraw     <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            line_start  <= (x_nxt == 11'd0);
            frame_start <= (x_nxt == 11'd0) && (y_nxt == 11'd0);
            hs_p0       <= hs_on ? SYNC_ON : SYNC_OFF;
            vs_p0       <= vs_on ? SYNC_ON : SYNC_OFF;
        end
    end

    // Sync delay line. Reset flushes every stage to the inactive level, so an
    // aborted pulse cannot leak out after reset is released.
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hsync = hs_p0;
        assign vsync = vs_p0;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_dly;
        logic [SYNC_DELAY-1:0] vs_dly;

        always_ff @(posedge clk) begin
            if (rst) begin
                hs_dly <= {SYNC_DELAY{SYNC_OFF}};
                vs_dly <= {SYNC_DELAY{SYNC_OFF}};
            end else begin
                hs_dly[0] <= hs_p0;
                vs_dly[0] <= vs_p0;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_dly[i] <= hs_dly[i-1];
                    vs_dly[i] <= vs_dly[i-1];
                end
            end
        end

        assign hsync = hs_dly[SYNC_DELAY-1];
        assign vsync = vs_dly[SYNC_DELAY-1];
    end

endmodule
